// File: rtl/wishbone_master.sv
// Wishbone classic single-transfer initiator: one bus cycle per valid/ready command, result on a valid/ready response.
// Optional ack watchdog is compiled in with `define WB_MASTER_TIMEOUT_EN.
module wishbone_master #(
    parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT_CYCLES     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t state, state_nxt;
    logic   cmd_fire, bus_done, bus_abort, rsp_fire;
    logic   timeout_hit;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] bus_cnt;

    // bus_cnt == n-1 during the n-th BUS cycle, so expiry lands on the TIMEOUT_CYCLES-th edge
    assign timeout_hit = (bus_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            bus_cnt   <= '0;
            rsp_err_o <= 1'b0;
        end else begin
            if (cmd_fire)
                bus_cnt <= '0;
            else if (state == BUS)
                bus_cnt <= bus_cnt + 1'b1;
            if (bus_done)
                rsp_err_o <= 1'b0;
            else if (bus_abort)
                rsp_err_o <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err_o   = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready_o = 1'b0;
        cmd_fire    = 1'b0;
        bus_done    = 1'b0;
        bus_abort   = 1'b0;
        rsp_fire    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    cmd_fire  = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                // ack takes priority over a simultaneous watchdog expiry
                if (wbm_ack_i) begin
                    bus_done  = 1'b1;
                    state_nxt = RESP;
                end else if (timeout_hit) begin
                    bus_abort = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
        end else begin
            if (cmd_fire) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= cmd_we_i;
                wbm_sel_o <= cmd_sel_i;
                wbm_adr_o <= WISHBONE_BASE_ADDR + cmd_adr_i;
                wbm_dat_o <= cmd_dat_i;
            end
            if (bus_done || bus_abort) begin
                wbm_cyc_o   <= 1'b0;
                wbm_stb_o   <= 1'b0;
                rsp_valid_o <= 1'b1;
                rsp_dat_o   <= (bus_done && !wbm_we_o) ? wbm_dat_i : 32'h0;
            end
            if (rsp_fire)
                rsp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master; timeout scenarios follow `WB_MASTER_TIMEOUT_EN.
module tb_wishbone_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [3:0]  cmd_sel_i = '0;
    logic [31:0] cmd_adr_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;

    int errors = 0;
    int checks = 0;

    wishbone_master dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_n_i  (wb_rst_n_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_sel_i   (cmd_sel_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called on a negedge in IDLE; returns on the negedge after the handshake edge.
    task automatic start_cmd(input logic we, input logic [3:0] sel, input logic [31:0] off,
                             input logic [31:0] dat);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_sel_i   = sel;
        cmd_adr_i   = off;
        cmd_dat_i   = dat;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        cmd_dat_i   = 32'hDEAD_BEEF;
        cmd_adr_i   = 32'h0000_0FF0;
        cmd_sel_i   = 4'h0;
    endtask

    // Ack is sampled on the k-th edge after the handshake; counts cycles with cyc high
    // and whether adr/dat/we/stb stayed stable throughout.
    task automatic ack_in(input int k, input logic [31:0] rd, input logic [31:0] exp_adr,
                          input logic [31:0] exp_dat, output int hi, output logic stable);
        hi = 0;
        stable = 1'b1;
        for (int i = 1; i <= k; i++) begin
            if (i == k) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = rd;
            end
            if (wbm_cyc_o) hi++;
            if (wbm_adr_o !== exp_adr || wbm_dat_o !== exp_dat || wbm_stb_o !== wbm_cyc_o)
                stable = 1'b0;
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
        end
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h5555_AAAA;
    endtask

    task automatic rsp_take();
        rsp_ready_i = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
        check("take_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("take_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int   hi;
        logic st;

        // Reset state
        repeat (2) @(negedge wb_clk_i);
        check("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        check("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
        check("rst_adr", wbm_adr_o, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("rst_rsp_dat", rsp_dat_o, 32'h0);
        check("rst_rsp_err", {31'b0, rsp_err_o}, 32'd0);
        check("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);

        // Write, ack one cycle after stb
        wbm_dat_i = 32'h7777_7777;
        start_cmd(1'b1, 4'hF, 32'h4, 32'hA5A5_0001);
        check("wr_cyc", {31'b0, wbm_cyc_o}, 32'd1);
        check("wr_stb", {31'b0, wbm_stb_o}, 32'd1);
        check("wr_adr", wbm_adr_o, 32'h3000_0004);
        check("wr_we", {31'b0, wbm_we_o}, 32'd1);
        check("wr_sel", {28'b0, wbm_sel_o}, 32'hF);
        check("wr_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
        ack_in(1, 32'h7777_7777, 32'h3000_0004, 32'hA5A5_0001, hi, st);
        check("wr_hi_cycles", hi, 32'd1);
        check("wr_stable", {31'b0, st}, 32'd1);
        check("wr_cyc_drop", {31'b0, wbm_cyc_o}, 32'd0);
        check("wr_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        check("wr_rsp_dat", rsp_dat_o, 32'h0);
        check("wr_rsp_err", {31'b0, rsp_err_o}, 32'd0);
        rsp_take();

        // Read with a 5-cycle ack delay, then hold the response 4 cycles
        start_cmd(1'b0, 4'h3, 32'h8, 32'h0);
        check("rd_adr", wbm_adr_o, 32'h3000_0008);
        check("rd_we", {31'b0, wbm_we_o}, 32'd0);
        ack_in(5, 32'h1234_5678, 32'h3000_0008, 32'h0, hi, st);
        check("rd_hi_cycles", hi, 32'd5);
        check("rd_stable", {31'b0, st}, 32'd1);
        check("rd_cyc_drop", {31'b0, wbm_cyc_o}, 32'd0);
        check("rd_rsp_dat", rsp_dat_o, 32'h1234_5678);
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("hold_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
            check("hold_rsp_dat", rsp_dat_o, 32'h1234_5678);
            check("hold_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
            check("hold_cyc", {31'b0, wbm_cyc_o}, 32'd0);
            @(negedge wb_clk_i);
        end
        cmd_valid_i = 1'b0;
        rsp_take();
        check("idle_adr_retained", wbm_adr_o, 32'h3000_0008);

`ifdef WB_MASTER_TIMEOUT_EN
        // No ack: abort after 16 BUS cycles
        wbm_dat_i = 32'hFACE_FACE;
        start_cmd(1'b0, 4'hF, 32'h10, 32'h0);
        hi = 0;
        for (int i = 0; i < 40 && !rsp_valid_o; i++) begin
            if (wbm_cyc_o) hi++;
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
        end
        check("to_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        check("to_hi_cycles", hi, 32'd16);
        check("to_cyc_drop", {31'b0, wbm_cyc_o}, 32'd0);
        check("to_rsp_err", {31'b0, rsp_err_o}, 32'd1);
        check("to_rsp_dat", rsp_dat_o, 32'h0);
        rsp_take();

        // Ack on the 16th cycle wins over expiry
        start_cmd(1'b0, 4'hF, 32'h14, 32'h0);
        ack_in(16, 32'hCAFE_F00D, 32'h3000_0014, 32'h0, hi, st);
        check("to16_hi_cycles", hi, 32'd16);
        check("to16_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        check("to16_rsp_err", {31'b0, rsp_err_o}, 32'd0);
        check("to16_rsp_dat", rsp_dat_o, 32'hCAFE_F00D);
        rsp_take();
`else
        // Without the watchdog the bus waits indefinitely
        start_cmd(1'b0, 4'hF, 32'h10, 32'h0);
        repeat (20) @(negedge wb_clk_i);
        check("wait_cyc", {31'b0, wbm_cyc_o}, 32'd1);
        check("wait_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        ack_in(1, 32'hCAFE_F00D, 32'h3000_0010, 32'h0, hi, st);
        check("wait_rsp_err", {31'b0, rsp_err_o}, 32'd0);
        check("wait_rsp_dat", rsp_dat_o, 32'hCAFE_F00D);
        rsp_take();
`endif

        // Address wrap, then spurious ack in IDLE
        start_cmd(1'b0, 4'h1, 32'hD000_0000, 32'h0);
        check("wrap_adr", wbm_adr_o, 32'h0000_0000);
        ack_in(1, 32'h0BAD_0000, 32'h0, 32'h0, hi, st);
        check("wrap_rsp_dat", rsp_dat_o, 32'h0BAD_0000);
        rsp_take();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hFFFF_FFFF;
        repeat (2) @(negedge wb_clk_i);
        wbm_ack_i = 1'b0;
        check("spur_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        check("spur_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("spur_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        check("spur_rsp_dat", rsp_dat_o, 32'h0BAD_0000);

        // Reset mid-BUS
        start_cmd(1'b1, 4'hF, 32'h20, 32'h1111_2222);
        check("mid_cyc_before", {31'b0, wbm_cyc_o}, 32'd1);
        wb_rst_n_i = 1'b0;
        #1;
        check("mid_rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        check("mid_rst_stb", {31'b0, wbm_stb_o}, 32'd0);
        check("mid_rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("mid_rst_adr", wbm_adr_o, 32'h0);
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);
        check("post_rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        check("post_rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        start_cmd(1'b1, 4'hC, 32'h24, 32'h3333_4444);
        check("post_adr", wbm_adr_o, 32'h3000_0024);
        ack_in(2, 32'h9999_9999, 32'h3000_0024, 32'h3333_4444, hi, st);
        check("post_hi_cycles", hi, 32'd2);
        check("post_stable", {31'b0, st}, 32'd1);
        check("post_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        check("post_rsp_dat", rsp_dat_o, 32'h0);
        rsp_take();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wishbone_master.md
# wishbone_master

Wishbone classic single-transfer initiator that turns a simple valid/ready command stream into one bus cycle per command and returns the result on a valid/ready response stream. It drives the same Wishbone signal set our slave-side control blocks respond to, and we use it in test harnesses and on-chip sequencers to exercise those peripherals. Each transfer is a non-pipelined classic cycle with an optional abort watchdog. Exactly one transfer is outstanding at any time.

## Interface
- WISHBONE_BASE_ADDR, 32'h30000000, added to every command offset to form the bus address
- TIMEOUT_CYCLES, 16, number of bus-phase cycles to wait for ack before aborting (minimum 2; used only with watchdog compiled in)

- wb_clk_i  in  1  single clock; all logic rising-edge
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_sel_i  in  4  byte lanes
- cmd_adr_i  in  32  byte offset from WISHBONE_BASE_ADDR
- cmd_dat_i  in  32  write data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when high together with rsp_valid_o
- rsp_dat_o  out  32  read data; 0 for writes and aborts
- rsp_err_o  out  1  1 = transfer aborted by watchdog
- wbm_cyc_o, wbm_stb_o  out  1 each  bus cycle / strobe, always equal
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte lanes
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_ack_i  in  1  responder acknowledge
- wbm_dat_i  in  32  read data

## Operation
- FSM has three states: IDLE, BUS, RESP. Reset state is IDLE.
- IDLE
  - cmd_ready_o = 1.
  - On cmd_valid_i, latch we/sel/dat and wbm_adr_o = WISHBONE_BASE_ADDR + cmd_adr_i. The sum wraps modulo 2^32.
  - Go to BUS.
- BUS
  - cyc/stb held high.
  - we/sel/adr/dat held stable.
  - cmd_ready_o = 0.
- BUS, on ack sampled high
  - Read: capture wbm_dat_i into rsp_dat_o.
  - Write: set rsp_dat_o = 0.
  - Set rsp_err_o = 0, drop cyc/stb, go to RESP.
- RESP
  - rsp_valid_o = 1.
  - rsp_dat_o and rsp_err_o are stable until rsp_ready_i.
  - On the handshake, go to IDLE.
- wbm_ack_i outside BUS is ignored. No state change, no data capture.
- wbm_we_o, sel, adr and dat outputs retain their last values when idle.
- Registered outputs reset to 0: cyc, stb, we, sel, adr, dat, rsp_valid_o, rsp_dat_o, rsp_err_o.
- cmd_ready_o is combinational from state: 1 in IDLE after reset.
- Reset asserted mid-transfer drops cyc/stb immediately and asynchronously. No response is produced for the in-flight command.

## Timing
- Command handshake at edge N: cyc/stb are high after edge N.
- Ack high at edge N+k (k ≥ 1): cyc/stb are low and rsp_valid_o is high after edge N+k.
- Against a responder that acks one cycle after request, the first rsp_valid_o cycle follows edge N+1 (k=1).
- Response handshake at edge M: cmd_ready_o is high after edge M. Back-to-back throughput is therefore one transfer per 3 cycles minimum.
- cyc/stb are never asserted for two transfers without at least one low cycle between them.

## Configuration
- WB_MASTER_TIMEOUT_EN defined:
  - A bus-phase counter clears on entry to BUS and increments each BUS cycle.
  - If no ack arrives by the TIMEOUT_CYCLES-th BUS cycle, the transfer aborts: cyc/stb drop, rsp_err_o = 1, rsp_dat_o = 0, go to RESP.
  - An ack sampled on the same edge as expiry wins: normal completion, rsp_err_o = 0.
- Undefined:
  - No counter; BUS waits indefinitely.
  - rsp_err_o is a constant 0.

## Test plan
- Write offset 32'h4, dat 32'hA5A5_0001, sel 4'hF; responder acks one cycle after stb -> wbm_adr_o = 32'h3000_0004, we = 1, dat stable while stb high, one rsp with dat 0 and err 0.
- Read offset 32'h8; responder returns 32'h1234_5678 with a 5-cycle ack delay -> cyc/stb high for exactly 5 cycles, rsp_dat_o = 32'h1234_5678.
- Hold rsp_ready_i low 4 cycles after the response -> rsp_valid_o and data stable, cmd_ready_o low, no new cyc.
- With WB_MASTER_TIMEOUT_EN and no ack -> abort after 16 BUS cycles, rsp_err_o = 1, rsp_dat_o = 0. With ack on the 16th cycle -> err 0.
- Offset 32'hD000_0000 (sum overflows) -> wbm_adr_o = 32'h0000_0000. A spurious ack in IDLE changes nothing.
- Assert wb_rst_n_i low mid-BUS -> cyc/stb/rsp_valid_o = 0 immediately. After release, cmd_ready_o = 1 and the next transfer completes normally.
